// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered one-hot decoder.
// Optional scan sequencer is built only with DECODER_SCAN_EN defined.
package decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Widest output word the helper can describe; callers size it down.
    localparam int MAX_OUT_W = 1024;

    // All lines deasserted: zeros for active-high, ones for active-low.
    function automatic logic [MAX_OUT_W-1:0] inactive_word(input int active_low, input int out_w);
        logic [MAX_OUT_W-1:0] w;
        w = '0;
        for (int i = 0; i < MAX_OUT_W; i++) begin
            if (i < out_w && active_low != 0) w[i] = 1'b1;
        end
        return w;
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational N-to-M one-hot decoder with polarity select and range flag.
// Out-of-range codes produce the inactive word.
module onehot_dec #(
    parameter int IN_W       = 3,
    parameter int OUT_W      = 8,
    parameter int ACTIVE_LOW = 0
) (
    input  logic [IN_W-1:0]  code,
    output logic [OUT_W-1:0] lines,
    output logic             in_range
);

    localparam logic [IN_W:0] LIMIT = (IN_W+1)'(OUT_W);
    localparam logic          POL   = (ACTIVE_LOW != 0);

    assign in_range = ({1'b0, code} < LIMIT);

    for (genvar i = 0; i < OUT_W; i++) begin : g_line
        assign lines[i] = (code == IN_W'(i)) ^ POL;
    end

endmodule

// File: rtl/decoder_nw_seq.sv
// Registered N-to-M one-hot decoder with valid/ready capture, range check,
// selectable polarity and an optional scan sequencer (DECODER_SCAN_EN).
module decoder_nw_seq
    import decoder_pkg::*;
#(
    parameter int IN_W       = 3,
    parameter int OUT_W      = 8,
    parameter int ACTIVE_LOW = 0,
    parameter int DWELL_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_code,
    output logic [OUT_W-1:0]   outa,
    output logic               out_valid,
    output logic               code_err,
    input  logic               scan_start,
    input  logic               scan_dir,
    input  logic               scan_wrap,
    input  logic [DWELL_W-1:0] scan_dwell,
    output logic               scan_done
);

    localparam logic [OUT_W-1:0] INACT = OUT_W'(inactive_word(ACTIVE_LOW, OUT_W));

    state_t           state, nxt_state, state_d;
    logic [IN_W-1:0]  code, code_nxt;
    logic [OUT_W-1:0] dec_lines, outa_nxt;
    logic             dec_ok, valid_nxt, err_nxt, done_nxt, capture;

    assign capture = in_valid && in_ready;

`ifdef DECODER_SCAN_EN
    localparam logic [IN_W-1:0] TOP_CODE = IN_W'(OUT_W-1);
    localparam logic [IN_W-1:0] ONE      = IN_W'(1);

    logic [DWELL_W-1:0] cnt, cnt_nxt, dwell_lat, dwell_nxt;
    logic               dir_lat, dir_nxt, wrap_lat, wrap_nxt, scan_go, at_end;

    assign scan_go  = en && scan_start && (state != ST_SCAN);
    assign in_ready = en && (state != ST_SCAN) && !scan_start;
    assign at_end   = (dir_lat == DIR_DOWN) ? (code == '0) : (code == TOP_CODE);
`else
    logic unused_scan;
    assign unused_scan = ^{scan_start, scan_dir, scan_wrap, scan_dwell};
    assign in_ready    = en;
`endif

    // Next state and next code: enable, scan start, capture, then scan stepping
    always_comb begin
        nxt_state = state;
        code_nxt  = code;
        done_nxt  = 1'b0;
`ifdef DECODER_SCAN_EN
        cnt_nxt   = cnt;
        dwell_nxt = dwell_lat;
        dir_nxt   = dir_lat;
        wrap_nxt  = wrap_lat;
`endif
        if (!en) begin
            nxt_state = ST_IDLE;
        end
`ifdef DECODER_SCAN_EN
        else if (scan_go) begin
            nxt_state = ST_SCAN;
            code_nxt  = (scan_dir == DIR_DOWN) ? TOP_CODE : '0;
            cnt_nxt   = scan_dwell;
            dwell_nxt = scan_dwell;
            dir_nxt   = scan_dir;
            wrap_nxt  = scan_wrap;
        end
`endif
        else if (capture) begin
            nxt_state = ST_HOLD;
            code_nxt  = in_code;
        end
`ifdef DECODER_SCAN_EN
        else if (state == ST_SCAN) begin
            if (cnt != '0) begin
                cnt_nxt = cnt - DWELL_W'(1);
            end else begin
                cnt_nxt = dwell_lat;
                if (!at_end) begin
                    code_nxt = (dir_lat == DIR_DOWN) ? code - ONE : code + ONE;
                end else if (wrap_lat) begin
                    code_nxt = (dir_lat == DIR_DOWN) ? TOP_CODE : '0;
                end else begin
                    nxt_state = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
        end
`endif
    end

    // Single decoder in front of the output register, fed the next code
    onehot_dec #(
        .IN_W       (IN_W),
        .OUT_W      (OUT_W),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_dec (
        .code     (code_nxt),
        .lines    (dec_lines),
        .in_range (dec_ok)
    );

    // Output decode: an out-of-range capture drops to IDLE and flags an error
    always_comb begin
        state_d = nxt_state;
        err_nxt = 1'b0;
        if (nxt_state != ST_IDLE && !dec_ok) begin
            state_d = ST_IDLE;
            err_nxt = capture;
        end
        valid_nxt = (state_d != ST_IDLE);
        outa_nxt  = valid_nxt ? dec_lines : INACT;
    end

    // State, code and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            code      <= '0;
            outa      <= INACT;
            out_valid <= 1'b0;
            code_err  <= 1'b0;
            scan_done <= 1'b0;
        end else begin
            state     <= state_d;
            code      <= code_nxt;
            outa      <= outa_nxt;
            out_valid <= valid_nxt;
            code_err  <= err_nxt;
            scan_done <= done_nxt;
        end
    end

`ifdef DECODER_SCAN_EN
    // Scan dwell counter and start-time latches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            dwell_lat <= '0;
            dir_lat   <= DIR_UP;
            wrap_lat  <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            dwell_lat <= dwell_nxt;
            dir_lat   <= dir_nxt;
            wrap_lat  <= wrap_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_decoder_nw_seq.sv
// Self-checking bench: table-driven direct decode on two configurations
// (3->8 active-high and 3->6 active-low) plus hand-written scan, enable
// and reset sequences. Scan sequences apply when DECODER_SCAN_EN is defined.
module tb_decoder_nw_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DUT A: IN_W=3, OUT_W=8, active-high
    logic       en_a, iv_a, rdy_a, ss_a, dir_a, wrap_a;
    logic [2:0] code_a;
    logic [7:0] dwell_a, outa_a;
    logic       vld_a, err_a, done_a;

    // DUT B: IN_W=3, OUT_W=6, active-low
    logic       en_b, iv_b, rdy_b, ss_b, dir_b, wrap_b;
    logic [2:0] code_b;
    logic [7:0] dwell_b;
    logic [5:0] outa_b;
    logic       vld_b, err_b, done_b;

    decoder_nw_seq #(.IN_W(3), .OUT_W(8), .ACTIVE_LOW(0), .DWELL_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .in_valid(iv_a), .in_ready(rdy_a),
        .in_code(code_a), .outa(outa_a), .out_valid(vld_a), .code_err(err_a),
        .scan_start(ss_a), .scan_dir(dir_a), .scan_wrap(wrap_a),
        .scan_dwell(dwell_a), .scan_done(done_a)
    );

    decoder_nw_seq #(.IN_W(3), .OUT_W(6), .ACTIVE_LOW(1), .DWELL_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .in_valid(iv_b), .in_ready(rdy_b),
        .in_code(code_b), .outa(outa_b), .out_valid(vld_b), .code_err(err_b),
        .scan_start(ss_b), .scan_dir(dir_b), .scan_wrap(wrap_b),
        .scan_dwell(dwell_b), .scan_done(done_b)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       sel_b;   // 0 drives DUT A, 1 drives DUT B
        logic       iv;
        logic [2:0] code;
        logic [7:0] exp_out;
        logic       exp_vld;
        logic       exp_err;
    } vec_t;

    vec_t tbl[16];

    initial begin
        // Direct decode on A: 5, then 7 down to 0 back-to-back, then idle hold
        tbl[0]  = '{1'b0, 1'b1, 3'd5, 8'h20, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 3'd7, 8'h80, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 3'd6, 8'h40, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 3'd5, 8'h20, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 3'd4, 8'h10, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 3'd3, 8'h08, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 3'd2, 8'h04, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 3'd1, 8'h02, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 3'd0, 8'h01, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 3'd6, 8'h01, 1'b1, 1'b0};
        // Range check and polarity on B (OUT_W=6, active-low)
        tbl[10] = '{1'b1, 1'b1, 3'd6, 8'h3F, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 3'd0, 8'h3F, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 3'd2, 8'h3B, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 3'd5, 8'h1F, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 3'd7, 8'h3F, 1'b0, 1'b1};
        tbl[15] = '{1'b1, 1'b0, 3'd7, 8'h3F, 1'b0, 1'b0};

        rst_n = 1'b0;
        {en_a, iv_a, ss_a, dir_a, wrap_a} = '0; code_a = '0; dwell_a = '0;
        {en_b, iv_b, ss_b, dir_b, wrap_b} = '0; code_b = '0; dwell_b = '0;

        // Reset values
        #12;
        chk("rst_outa_a", outa_a, 8'h00);
        chk("rst_outa_b", outa_b, 6'h3F);
        chk("rst_vld_a",  vld_a,  0);
        chk("rst_err_a",  err_a,  0);
        chk("rst_done_a", done_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        en_a = 1'b1;
        en_b = 1'b1;
        step();
        chk("idle_outa_a", outa_a, 8'h00);
        chk("idle_rdy_a",  rdy_a,  1);

        // Table-driven direct decode
        foreach (tbl[i]) begin
            iv_a = 1'b0;
            iv_b = 1'b0;
            if (tbl[i].sel_b) begin
                iv_b = tbl[i].iv; code_b = tbl[i].code;
            end else begin
                iv_a = tbl[i].iv; code_a = tbl[i].code;
            end
            step();
            if (tbl[i].sel_b) begin
                chk($sformatf("vec%0d_outa_b", i), {2'b00, outa_b}, tbl[i].exp_out);
                chk($sformatf("vec%0d_vld_b", i),  vld_b, tbl[i].exp_vld);
                chk($sformatf("vec%0d_err_b", i),  err_b, tbl[i].exp_err);
            end else begin
                chk($sformatf("vec%0d_outa_a", i), outa_a, tbl[i].exp_out);
                chk($sformatf("vec%0d_vld_a", i),  vld_a, tbl[i].exp_vld);
                chk($sformatf("vec%0d_err_a", i),  err_a, tbl[i].exp_err);
            end
        end
        iv_a = 1'b0;
        iv_b = 1'b0;

`ifdef DECODER_SCAN_EN
        // Scan up, dwell 2, single pass: 8 lines x 3 cycles, then one done pulse
        ss_a = 1'b1; dir_a = 1'b0; wrap_a = 1'b0; dwell_a = 8'd2;
        #1 chk("scan_start_rdy", rdy_a, 0);
        step();
        ss_a = 1'b0;
        for (int k = 0; k < 24; k++) begin
            chk($sformatf("scanup_outa_%0d", k), outa_a, 32'(8'h01 << (k / 3)));
            chk($sformatf("scanup_vld_%0d", k),  vld_a, 1);
            chk($sformatf("scanup_done_%0d", k), done_a, 0);
            step();
        end
        chk("scanup_end_outa", outa_a, 8'h00);
        chk("scanup_end_vld",  vld_a, 0);
        chk("scanup_end_done", done_a, 1);
        step();
        chk("scanup_done_once", done_a, 0);

        // Scan down, dwell 0, wrapping, in_valid held high; restart requests ignored
        ss_a = 1'b1; dir_a = 1'b1; wrap_a = 1'b1; dwell_a = 8'd0;
        iv_a = 1'b1; code_a = 3'd1;
        step();
        ss_a = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            ss_a  = (k >= 3 && k <= 5);
            dir_a = 1'b0;
            chk($sformatf("scandn_outa_%0d", k), outa_a, 32'(8'h80 >> (k % 8)));
            chk($sformatf("scandn_rdy_%0d", k),  rdy_a, 0);
            if (k == 12) en_a = 1'b0;   // drop enable while code 3 is shown
            step();
        end
        ss_a = 1'b0;
        chk("abort_outa", outa_a, 8'h00);
        chk("abort_vld",  vld_a, 0);
        chk("abort_done", done_a, 0);
        iv_a = 1'b0;
        en_a = 1'b1;
        #1 chk("abort_idle_rdy", rdy_a, 1);
        step();
        chk("abort_idle_outa", outa_a, 8'h00);
`else
        // Without the sequencer, scan_start is ignored and the code is captured
        ss_a = 1'b1; iv_a = 1'b1; code_a = 3'd4;
        #1 chk("noscan_rdy", rdy_a, 1);
        step();
        ss_a = 1'b0; iv_a = 1'b0;
        chk("noscan_outa", outa_a, 8'h10);
        chk("noscan_vld",  vld_a, 1);
        chk("noscan_done", done_a, 0);
        step();
        chk("noscan_done2", done_a, 0);
`endif

        // Async reset during HOLD clears outputs before the next edge
        iv_a = 1'b1; code_a = 3'd2;
        step();
        iv_a = 1'b0;
        chk("hold_outa", outa_a, 8'h04);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_outa_a", outa_a, 8'h00);
        chk("arst_vld_a",  vld_a, 0);
        chk("arst_outa_b", outa_b, 6'h3F);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_outa", outa_a, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
